// File: rtl/cla_mp_sequencer.sv
// Multi-precision add/subtract sequencer.
// A single DATA_WID-bit carry-lookahead slice is reused once per word, LSW first.
// The carry between words is held in a register.

// Parallel-prefix carry-lookahead adder used as the shared slice.
module cla_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 0;

    logic [WIDTH-1:0] prop;
    logic [WIDTH-1:0] gen_lvl  [0:LEVELS];
    logic [WIDTH-1:0] prop_lvl [0:LEVELS];
    logic [WIDTH:0]   carry;

    // Kogge-Stone prefix tree. Carry-in is folded into bit 0's generate, so a
    // group reaching bit 0 needs no propagate term.
    always_comb begin
        prop        = a ^ b;
        gen_lvl[0]  = a & b;
        gen_lvl[0][0] = (a[0] & b[0]) | (prop[0] & cin);
        prop_lvl[0] = prop;
        for (int l = 0; l < int'(LEVELS); l++) begin
            gen_lvl[l+1]  = gen_lvl[l] | (prop_lvl[l] & (gen_lvl[l] << (1 << l)));
            prop_lvl[l+1] = prop_lvl[l] & (prop_lvl[l] << (1 << l));
        end
        carry = {gen_lvl[LEVELS], cin};
        sum   = prop ^ carry[WIDTH-1:0];
        cout  = carry[WIDTH];
    end

endmodule

// Sequencer: accept operands, run WORDS slice additions, hold result until taken.
module cla_mp_sequencer #(
    parameter int unsigned DATA_WID = 16,
    parameter int unsigned WORDS    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      op_sub,
    input  logic [WORDS*DATA_WID-1:0] a,
    input  logic [WORDS*DATA_WID-1:0] b,
    input  logic                      carry_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WORDS*DATA_WID-1:0] result,
    output logic                      carry_out,
    output logic                      overflow
);

    localparam int unsigned TOT_WID = WORDS * DATA_WID;
    localparam int unsigned IDX_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q;
    logic [TOT_WID-1:0] a_q;
    logic [TOT_WID-1:0] b_q;
    logic               c_q;
    logic [TOT_WID-1:0] result_q;
    logic               carry_out_q;
    logic               overflow_q;

    logic [DATA_WID-1:0] slice_a;
    logic [DATA_WID-1:0] slice_b;
    logic [DATA_WID-1:0] slice_sum;
    logic                slice_cout;
    logic                accept;
    logic                last_word;

    assign slice_a   = a_q[idx_q*DATA_WID +: DATA_WID];
    assign slice_b   = b_q[idx_q*DATA_WID +: DATA_WID];
    assign accept    = in_valid && in_ready;
    assign last_word = (idx_q == LAST_IDX);

    cla_adder #(
        .WIDTH (DATA_WID)
    ) u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (c_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept)    state_d = StRun;
            StRun:   if (last_word) state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
    end

    // Datapath: operand capture, per-word accumulate, flags on the final word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= 1'b0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            if (state_q == StIdle && accept) begin
                a_q   <= a;
                b_q   <= op_sub ? ~b : b;
                c_q   <= carry_in;
                idx_q <= '0;
            end else if (state_q == StRun) begin
                result_q[idx_q*DATA_WID +: DATA_WID] <= slice_sum;
                c_q <= slice_cout;
                if (last_word) begin
                    idx_q       <= '0;
                    carry_out_q <= slice_cout;
                    // Sign of the MSW sum disagrees with equal-signed operands.
                    overflow_q  <= (a_q[TOT_WID-1] == b_q[TOT_WID-1]) &&
                                   (slice_sum[DATA_WID-1] != a_q[TOT_WID-1]);
                end else begin
                    idx_q <= idx_q + 1'b1;
                end
            end
        end
    end

    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_cla_mp_sequencer.sv
// Self-checking bench for cla_mp_sequencer (DATA_WID=16, WORDS=4).
module tb_cla_mp_sequencer;

    localparam int DW    = 16;
    localparam int WORDS = 4;
    localparam int TW    = DW * WORDS;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic          op_sub;
    logic [TW-1:0] a;
    logic [TW-1:0] b;
    logic          carry_in;
    logic          out_valid;
    logic          out_ready;
    logic [TW-1:0] result;
    logic          carry_out;
    logic          overflow;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string         name;
        logic [TW-1:0] va;
        logic [TW-1:0] vb;
        logic          sub;
        logic          cin;
        logic [TW-1:0] exp_res;
        logic          exp_co;
        logic          exp_ov;
    } vec_t;

    vec_t vecs[8];

    cla_mp_sequencer #(
        .DATA_WID (DW),
        .WORDS    (WORDS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sub    (op_sub),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Accept one operation, scramble inputs during RUN, check latency and outputs, take result.
    task automatic run_op(input vec_t v);
        int n;
        a = v.va; b = v.vb; op_sub = v.sub; carry_in = v.cin; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = ~a; b = ~b; op_sub = ~op_sub; carry_in = ~carry_in;
        chk({v.name, "_in_ready_run"}, TW'(in_ready), TW'(0));
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({v.name, "_latency"}, TW'(n), TW'(WORDS));
        chk({v.name, "_result"}, result, v.exp_res);
        chk({v.name, "_carry_out"}, TW'(carry_out), TW'(v.exp_co));
        chk({v.name, "_overflow"}, TW'(overflow), TW'(v.exp_ov));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({v.name, "_out_valid_drop"}, TW'(out_valid), TW'(0));
        chk({v.name, "_in_ready_back"}, TW'(in_ready), TW'(1));
    endtask

    initial begin
        int   n;
        int   hits;
        int   hit_t[3];
        logic stray;
        logic [TW-1:0] held_res;

        vecs[0] = '{"add_carry",  64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0,
                    64'h0000_0000_0001_0000, 1'b0, 1'b0};
        vecs[1] = '{"full_ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 1'b1,
                    64'h0, 1'b1, 1'b0};
        vecs[2] = '{"sub_borrow", 64'h5, 64'h7, 1'b1, 1'b1,
                    64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
        vecs[3] = '{"sub_noborrow", 64'h7, 64'h5, 1'b1, 1'b1, 64'h2, 1'b1, 1'b0};
        vecs[4] = '{"add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
                    64'h8000_0000_0000_0000, 1'b0, 1'b1};
        vecs[5] = '{"sub_ovf", 64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b1,
                    64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
        vecs[6] = '{"add_mixed", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0,
                    64'h2222_2222_2222_2211, 1'b0, 1'b0};
        vecs[7] = '{"sub_cin0", 64'h0, 64'h0, 1'b1, 1'b0,
                    64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op_sub = 1'b0; a = '0; b = '0; carry_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", TW'(in_ready), TW'(1));
        chk("rst_out_valid", TW'(out_valid), TW'(0));
        chk("rst_result", result, TW'(0));
        chk("rst_flags", TW'({carry_out, overflow}), TW'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) run_op(vecs[i]);

        // Reset mid-RUN after two words have been written.
        a = vecs[6].va; b = vecs[6].vb; op_sub = 1'b0; carry_in = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("rst_run_out_valid", TW'(out_valid), TW'(0));
        chk("rst_run_result", result, TW'(0));
        chk("rst_run_flags", TW'({carry_out, overflow}), TW'(0));
        chk("rst_run_in_ready", TW'(in_ready), TW'(1));
        @(posedge clk); #1;
        rst_n = 1'b1;
        stray = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (out_valid || !in_ready) stray = 1'b1;
        end
        chk("rst_run_no_stray", TW'(stray), TW'(0));

        // Reset while in DONE with overflow set.
        a = vecs[4].va; b = vecs[4].vb; op_sub = 1'b0; carry_in = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
        chk("rst_done_reach", TW'(overflow), TW'(1));
        rst_n = 1'b0;
        #1;
        chk("rst_done_out_valid", TW'(out_valid), TW'(0));
        chk("rst_done_result", result, TW'(0));
        chk("rst_done_flags", TW'({carry_out, overflow}), TW'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Backpressure: hold DONE for 5 cycles while inputs churn.
        a = vecs[4].va; b = vecs[4].vb; op_sub = 1'b0; carry_in = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
        chk("bp_latency", TW'(n), TW'(WORDS));
        held_res = vecs[4].exp_res;
        for (int k = 0; k < 5; k++) begin
            in_valid = k[0] ? 1'b0 : 1'b1;
            a = {$urandom, $urandom}; b = {$urandom, $urandom};
            op_sub = ~op_sub; carry_in = ~carry_in;
            @(posedge clk); #1;
            chk("bp_out_valid", TW'(out_valid), TW'(1));
            chk("bp_result", result, held_res);
            chk("bp_flags", TW'({carry_out, overflow}), TW'(2'b01));
            chk("bp_in_ready", TW'(in_ready), TW'(0));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_in_ready", TW'(in_ready), TW'(1));

        // Back-to-back stream of 1+1 with out_ready held high.
        a = 64'h1; b = 64'h1; op_sub = 1'b0; carry_in = 1'b0; in_valid = 1'b1;
        n = 0; hits = 0;
        while (hits < 3 && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) chk("stream_accept", TW'(in_ready), TW'(0));
            if (out_valid) begin
                hit_t[hits] = n;
                chk("stream_result", result, TW'(2));
                hits++;
            end
        end
        in_valid = 1'b0;
        chk("stream_count", TW'(hits), TW'(3));
        if (hits == 3) begin
            chk("stream_first", TW'(hit_t[0]), TW'(WORDS + 1));
            chk("stream_gap1", TW'(hit_t[1] - hit_t[0]), TW'(WORDS + 2));
            chk("stream_gap2", TW'(hit_t[2] - hit_t[1]), TW'(WORDS + 2));
        end
        n = 0;
        while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
        chk("stream_drain", TW'(in_ready), TW'(1));
        out_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
